pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline.
- Generates control for PC, IF/ID and ID/EX:
  - load-use stall
  - branch flush
  - global cpu stall during a data-cache miss
- Runs a small miss-handshake FSM and a miss watchdog, and keeps saturating performance counters.
- Sits beside the hazard-detection logic in ID. Drives the Stall/Flush/cpu_stall inputs of every pipeline register.

Parameters:
- CNT_W, 32, width of each performance counter.
- MISS_TIMEOUT, 1024, number of MISS-state cycles before the watchdog error is raised (must be ≥2).
- TO_W, 11, width of the watchdog counter; must hold MISS_TIMEOUT.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- ID_rs1_i  input  5  rs1 of the instruction in ID
- ID_rs2_i  input  5  rs2 of the instruction in ID
- EX_rd_i  input  5  rd of the instruction in EX
- EX_MemRead_i  input  1  instruction in EX is a load
- ID_branch_taken_i  input  1  branch resolved taken in ID this cycle
- MEM_MemRead_i  input  1  MEM-stage load
- MEM_MemWrite_i  input  1  MEM-stage store
- dcache_miss_i  input  1  combinational miss indication for the current MEM access
- dcache_ready_i  input  1  one-cycle pulse: line fill complete
- pc_write_o  output  1  PC update enable
- stall_o  output  1  IF/ID hold
- flush_o  output  1  IF/ID flush (insert NOP)
- bubble_o  output  1  ID/EX control zeroing
- cpu_stall_o  output  1  freeze all pipeline registers and PC
- err_o  output  1  sticky watchdog timeout
- loaduse_cnt_o  output  CNT_W  load-use stall count
- flush_cnt_o  output  CNT_W  branch flush count
- miss_cyc_o  output  CNT_W  cycles with cpu_stall_o=1

Behaviour:
- Load-use hazard `lu` is combinational:
  - `lu` = EX_MemRead_i & EX_rd_i≠0 & (EX_rd_i==ID_rs1_i | EX_rd_i==ID_rs2_i).
- Memory access `macc` = MEM_MemRead_i | MEM_MemWrite_i.
- FSM states: IDLE, MISS, RESUME.
  - IDLE → MISS when macc & dcache_miss_i.
  - MISS → RESUME on dcache_ready_i.
  - RESUME → IDLE unconditionally.
  - In RESUME, dcache_miss_i is ignored (stale miss of the instruction now completing).
- cpu_stall_o (combinational):
  - 1 in IDLE when macc & dcache_miss_i (stall begins in the detect cycle, zero latency).
  - 1 throughout MISS, including the cycle dcache_ready_i is high.
  - 0 in RESUME.
  - 0 otherwise.
  - dcache_miss_i without macc is ignored.
- Priority: cpu_stall_o > lu > ID_branch_taken_i.
  - While cpu_stall_o=1: stall_o, flush_o, bubble_o = 0 and pc_write_o = 0.
  - Else if lu: stall_o=1, bubble_o=1, pc_write_o=0, flush_o=0. A taken branch in the same cycle is suppressed; it re-resolves next cycle.
  - Else if ID_branch_taken_i: flush_o=1, pc_write_o=1, stall_o=0, bubble_o=0.
  - Else: pc_write_o=1, all other controls 0.
- Watchdog:
  - TO_W-bit counter cleared on entry to MISS; increments each MISS cycle.
  - When it reaches MISS_TIMEOUT, err_o sets and stays set until reset.
  - The FSM remains in MISS; the counter holds at MISS_TIMEOUT.
- Counters (all CNT_W-bit, saturating at all-ones, never wrap), updated at the clock edge:
  - loaduse_cnt_o +1 each cycle lu wins arbitration.
  - flush_cnt_o +1 each cycle flush_o=1.
  - miss_cyc_o +1 each cycle cpu_stall_o=1.
- Reset: asynchronous, at any time including mid-MISS.
  - FSM returns to IDLE; watchdog counter, all counters and err_o cleared.
  - Combinational outputs follow inputs immediately (IDLE state).
- All non-counter outputs are combinational from state and inputs; no added latency.

Test Plan:
- Load-use: EX_MemRead_i=1, EX_rd_i=5, ID_rs2_i=5, no miss → stall_o=1, bubble_o=1, pc_write_o=0 for that cycle; loaduse_cnt_o=1 after the edge. Repeat with EX_rd_i=0 → no stall.
- Branch vs load-use: ID_branch_taken_i=1 alone → flush_o=1, pc_write_o=1, flush_cnt_o=1. Same with lu true → flush_o=0, stall_o=1, flush_cnt_o unchanged.
- Miss sequence: MEM_MemRead_i=1 & dcache_miss_i=1 at cycle 0, dcache_ready_i pulse at cycle 10:
  - cpu_stall_o=1 for cycles 0–10, 0 at cycle 11 (RESUME) even with dcache_miss_i still 1.
  - IDLE at cycle 12; miss_cyc_o=11.
- Stall masking: lu and ID_branch_taken_i asserted during MISS → stall_o, flush_o, bubble_o, pc_write_o all 0; loaduse_cnt_o and flush_cnt_o unchanged.
- Watchdog: MISS_TIMEOUT=8, miss with no ready → err_o rises after 8 MISS cycles and stays high; a late ready moves to RESUME with err_o still 1.
- Reset mid-MISS: assert rst_i asynchronously at cycle 5 of a miss → cpu_stall_o drops immediately if no miss is present; counters and err_o = 0. Saturation check with CNT_W=4: 20 load-use cycles → loaduse_cnt_o=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from ID/EX/MEM and the D-cache,
// plus the stall/flush controls and performance counters sent back to the pipeline.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       ID_rs1_i;
  logic [4:0]       ID_rs2_i;
  logic [4:0]       EX_rd_i;
  logic             EX_MemRead_i;
  logic             ID_branch_taken_i;
  logic             MEM_MemRead_i;
  logic             MEM_MemWrite_i;
  logic             dcache_miss_i;
  logic             dcache_ready_i;
  logic             pc_write_o;
  logic             stall_o;
  logic             flush_o;
  logic             bubble_o;
  logic             cpu_stall_o;
  logic             err_o;
  logic [CNT_W-1:0] loaduse_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] miss_cyc_o;

  // Pipeline side: supplies hazard sources and consumes the controls.
  modport master (
    output ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, ID_branch_taken_i,
           MEM_MemRead_i, MEM_MemWrite_i, dcache_miss_i, dcache_ready_i,
    input  pc_write_o, stall_o, flush_o, bubble_o, cpu_stall_o, err_o,
           loaduse_cnt_o, flush_cnt_o, miss_cyc_o
  );

  // Controller side.
  modport slave (
    input  ID_rs1_i, ID_rs2_i, EX_rd_i, EX_MemRead_i, ID_branch_taken_i,
           MEM_MemRead_i, MEM_MemWrite_i, dcache_miss_i, dcache_ready_i,
    output pc_write_o, stall_o, flush_o, bubble_o, cpu_stall_o, err_o,
           loaduse_cnt_o, flush_cnt_o, miss_cyc_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/stall sequencer: load-use stall, branch flush, D-cache miss
// freeze with watchdog, and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned MISS_TIMEOUT = 1024,
  parameter int unsigned TO_W         = 11
) (
  input logic                    clk_i,
  input logic                    rst_i,
  pipeline_hazard_ctrl_if.slave  hz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_RESUME
  } state_t;

  state_t           state_q, state_d;
  logic             lu;
  logic             macc;
  logic             cpu_stall;
  logic             pc_write, stall, flush, bubble;
  logic [TO_W-1:0]  wd_q;
  logic             err_q;
  logic [CNT_W-1:0] loaduse_cnt_q, flush_cnt_q, miss_cyc_q;

  assign lu   = hz.EX_MemRead_i && (hz.EX_rd_i != 5'd0) &&
                ((hz.EX_rd_i == hz.ID_rs1_i) || (hz.EX_rd_i == hz.ID_rs2_i));
  assign macc = hz.MEM_MemRead_i || hz.MEM_MemWrite_i;

  // Miss FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and global freeze; the freeze starts in the detect cycle and
  // RESUME ignores the stale miss of the instruction now completing.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (macc && hz.dcache_miss_i) begin
          cpu_stall = 1'b1;
          state_d   = S_MISS;
        end
      end
      S_MISS: begin
        cpu_stall = 1'b1;
        if (hz.dcache_ready_i) state_d = S_RESUME;
      end
      S_RESUME: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control arbitration: freeze beats load-use, load-use beats branch flush.
  always_comb begin
    pc_write = 1'b0;
    stall    = 1'b0;
    flush    = 1'b0;
    bubble   = 1'b0;
    if (cpu_stall) begin
      pc_write = 1'b0;
    end else if (lu) begin
      stall  = 1'b1;
      bubble = 1'b1;
    end else if (hz.ID_branch_taken_i) begin
      flush    = 1'b1;
      pc_write = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  // Miss watchdog: counts MISS cycles, pins at the timeout and raises a sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else if (state_q == S_IDLE && state_d == S_MISS) begin
      wd_q <= '0;
    end else if (state_q == S_MISS && wd_q != TO_W'(MISS_TIMEOUT)) begin
      wd_q <= wd_q + TO_W'(1);
      if (wd_q == TO_W'(MISS_TIMEOUT - 1)) err_q <= 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      loaduse_cnt_q <= '0;
      flush_cnt_q   <= '0;
      miss_cyc_q    <= '0;
    end else begin
      if (lu && !cpu_stall && loaduse_cnt_q != '1) loaduse_cnt_q <= loaduse_cnt_q + CNT_W'(1);
      if (flush && flush_cnt_q != '1)              flush_cnt_q   <= flush_cnt_q + CNT_W'(1);
      if (cpu_stall && miss_cyc_q != '1)           miss_cyc_q    <= miss_cyc_q + CNT_W'(1);
    end
  end

  assign hz.pc_write_o    = pc_write;
  assign hz.stall_o       = stall;
  assign hz.flush_o       = flush;
  assign hz.bubble_o      = bubble;
  assign hz.cpu_stall_o   = cpu_stall;
  assign hz.err_o         = err_q;
  assign hz.loaduse_cnt_o = loaduse_cnt_q;
  assign hz.flush_cnt_o   = flush_cnt_q;
  assign hz.miss_cyc_o    = miss_cyc_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: decode table, directed miss/watchdog/reset
// sequences, and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned MTO   = 8;
  localparam int unsigned TO_W  = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MISS_TIMEOUT(MTO), .TO_W(TO_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .hz    (hz)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       exmr, br, mr, mw, miss;
    logic       pw, st, fl, bu, cs;
  } vec_t;

  vec_t tbl [10];

  // Behavioural model state
  bit in_miss, resuming, err_m;
  int miss_len, lu_cnt, fl_cnt, mc_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic exmr, br, mr, mw, miss, rdy);
    hz.ID_rs1_i = rs1; hz.ID_rs2_i = rs2; hz.EX_rd_i = rd;
    hz.EX_MemRead_i = exmr; hz.ID_branch_taken_i = br;
    hz.MEM_MemRead_i = mr; hz.MEM_MemWrite_i = mw;
    hz.dcache_miss_i = miss; hz.dcache_ready_i = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_miss = 0; resuming = 0; err_m = 0; miss_len = 0;
    lu_cnt = 0; fl_cnt = 0; mc_cnt = 0;
  endtask

  task automatic chk_ctrl(input string tag, input logic pw, st, fl, bu, cs);
    chk({tag, ".pc_write"},  32'(hz.pc_write_o),  32'(pw));
    chk({tag, ".stall"},     32'(hz.stall_o),     32'(st));
    chk({tag, ".flush"},     32'(hz.flush_o),     32'(fl));
    chk({tag, ".bubble"},    32'(hz.bubble_o),    32'(bu));
    chk({tag, ".cpu_stall"}, 32'(hz.cpu_stall_o), 32'(cs));
  endtask

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  initial begin
    // decode table, applied while reset holds the controller idle
    tbl[0] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[1] = '{0, 5, 5, 1, 0, 0, 0, 0,  0, 1, 0, 1, 0};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[3] = '{5, 0, 5, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0};
    tbl[4] = '{1, 2, 3, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0};
    tbl[5] = '{7, 1, 7, 1, 1, 0, 0, 0,  0, 1, 0, 1, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 1, 0, 1,  0, 0, 0, 0, 1};
    tbl[8] = '{4, 4, 4, 1, 1, 0, 1, 1,  0, 0, 0, 0, 1};
    tbl[9] = '{0, 0, 0, 0, 1, 1, 0, 0,  1, 0, 1, 0, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].exmr, tbl[i].br,
            tbl[i].mr, tbl[i].mw, tbl[i].miss, 1'b0);
      #1;
      chk_ctrl($sformatf("tbl%0d", i), tbl[i].pw, tbl[i].st, tbl[i].fl, tbl[i].bu, tbl[i].cs);
    end

    // reset state
    do_reset();
    chk_ctrl("rst", 1, 0, 0, 0, 0);
    chk("rst.err", 32'(hz.err_o), 0);
    chk("rst.lu_cnt", 32'(hz.loaduse_cnt_o), 0);
    chk("rst.fl_cnt", 32'(hz.flush_cnt_o), 0);
    chk("rst.mc_cnt", 32'(hz.miss_cyc_o), 0);

    // load-use, then rd=0 gives no stall
    drive(0, 5, 5, 1, 0, 0, 0, 0, 0); #1;
    chk_ctrl("lu", 0, 1, 0, 1, 0);
    tick();
    chk("lu.cnt", 32'(hz.loaduse_cnt_o), 1);
    drive(0, 0, 0, 1, 0, 0, 0, 0, 0); #1;
    chk_ctrl("lu_x0", 1, 0, 0, 0, 0);
    tick();
    chk("lu_x0.cnt", 32'(hz.loaduse_cnt_o), 1);

    // branch alone, then branch suppressed by load-use
    drive(0, 0, 0, 0, 1, 0, 0, 0, 0); #1;
    chk_ctrl("br", 1, 0, 1, 0, 0);
    tick();
    chk("br.cnt", 32'(hz.flush_cnt_o), 1);
    drive(9, 0, 9, 1, 1, 0, 0, 0, 0); #1;
    chk_ctrl("br_lu", 0, 1, 0, 1, 0);
    tick();
    chk("br_lu.fcnt", 32'(hz.flush_cnt_o), 1);
    chk("br_lu.lcnt", 32'(hz.loaduse_cnt_o), 2);

    // miss: detect at cycle 0, ready at cycle 10, resume at 11, idle at 12
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      if (c == 5) drive(3, 0, 3, 1, 1, 1, 0, 1, 0);
      else        drive(0, 0, 0, 0, 0, 1, 0, 1, (c == 10));
      #1;
      if (c <= 10)      chk_ctrl($sformatf("miss.c%0d", c), 0, 0, 0, 0, 1);
      else if (c == 11) chk_ctrl("miss.resume", 1, 0, 0, 0, 0);
      else begin
        chk_ctrl("miss.reidle", 0, 0, 0, 0, 1);
        chk("miss.mc_cnt", 32'(hz.miss_cyc_o), 11);
        chk("miss.lu_cnt", 32'(hz.loaduse_cnt_o), 0);
        chk("miss.fl_cnt", 32'(hz.flush_cnt_o), 0);
      end
      if (c < 12) tick();
    end

    // watchdog: err rises after MTO MISS cycles, survives a late ready
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= int'(MTO) + 3; k++) begin
      tick();
      chk($sformatf("wd.err%0d", k), 32'(hz.err_o), (k >= int'(MTO)) ? 1 : 0);
    end
    chk("wd.stall", 32'(hz.cpu_stall_o), 1);
    hz.dcache_ready_i = 1'b1;
    tick();
    hz.dcache_ready_i = 1'b0;
    #1;
    chk("wd.resume_cs", 32'(hz.cpu_stall_o), 0);
    chk("wd.resume_err", 32'(hz.err_o), 1);
    tick();

    // asynchronous reset in the middle of a miss clears everything
    drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) tick();
    #2;
    chk("arst.pre_cs", 32'(hz.cpu_stall_o), 1);
    rst = 1'b1;
    #1;
    chk("arst.cs", 32'(hz.cpu_stall_o), 0);
    chk("arst.err", 32'(hz.err_o), 0);
    chk("arst.mc_cnt", 32'(hz.miss_cyc_o), 0);
    chk("arst.fl_cnt", 32'(hz.flush_cnt_o), 0);
    tick();
    rst = 1'b0;

    // saturation
    do_reset();
    drive(6, 0, 6, 1, 0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("sat.lu_cnt", 32'(hz.loaduse_cnt_o), SAT);

    // randomized traffic against the behavioural model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit lu_e, macc_e, cs_e, fl_e, br_e;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        chk("rnd.rst_cnt", 32'(hz.miss_cyc_o), 0);
        continue;
      end
      drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
      #1;
      lu_e   = hz.EX_MemRead_i && hz.EX_rd_i != 0 &&
               (hz.EX_rd_i == hz.ID_rs1_i || hz.EX_rd_i == hz.ID_rs2_i);
      macc_e = hz.MEM_MemRead_i || hz.MEM_MemWrite_i;
      br_e   = hz.ID_branch_taken_i;
      cs_e   = in_miss || (!resuming && macc_e && hz.dcache_miss_i);
      fl_e   = !cs_e && !lu_e && br_e;
      chk_ctrl("rnd", !cs_e && !lu_e, !cs_e && lu_e, fl_e, !cs_e && lu_e, cs_e);
      tick();
      if (!cs_e && lu_e) lu_cnt = sat_inc(lu_cnt);
      if (fl_e)          fl_cnt = sat_inc(fl_cnt);
      if (cs_e)          mc_cnt = sat_inc(mc_cnt);
      if (resuming) resuming = 0;
      else if (in_miss) begin
        miss_len++;
        if (miss_len >= int'(MTO)) err_m = 1;
        if (hz.dcache_ready_i) begin in_miss = 0; resuming = 1; end
      end else if (macc_e && hz.dcache_miss_i) begin
        in_miss = 1; miss_len = 0;
      end
      chk("rnd.lu_cnt", 32'(hz.loaduse_cnt_o), lu_cnt);
      chk("rnd.fl_cnt", 32'(hz.flush_cnt_o), fl_cnt);
      chk("rnd.mc_cnt", 32'(hz.miss_cyc_o), mc_cnt);
      chk("rnd.err", 32'(hz.err_o), 32'(err_m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
